serial_pattern_detector: RTL

Downstream consumer of the D flip-flop stage: samples the registered serial bit stream on `q` and flags every occurrence of a fixed bit pattern. It holds a short bit history, raises a one-cycle `match` pulse on each detection and keeps a saturating count of detections for readout by the bench or by later stages.

---
 rtl/serial_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 24 ++
 rtl/serial_pattern_detector.sv | 86 ++++++++
 3 files changed

// File: rtl/serial_det_pkg.sv
// Shared constants and FSM state type for the serial pattern detector.
package serial_det_pkg;

  localparam int         DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1011;
  localparam int         DEF_CNT_W     = 8;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_t;

  // Bits needed to hold a fill level running 0..pattern_w inclusive.
  function automatic int fill_bits(input int pattern_w);
    return $clog2(pattern_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import serial_det_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector with registered match pulse and saturating match count.
// Define SERIAL_DET_OVERLAP_EN to allow overlapping detections.
module serial_pattern_detector
  import serial_det_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
  parameter int                   CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic [PATTERN_W-1:0] history
);

  localparam int                FW   = fill_bits(PATTERN_W);
  localparam logic [FW-1:0]     FULL = FW'(PATTERN_W);

  det_state_t           state;
  logic [FW-1:0]        fill;
  logic [FW-1:0]        fill_next;
  logic [PATTERN_W-1:0] hist_next;
  logic                 accept;
  logic                 hit;

  // Detection looks at the post-edge history so match can be registered on the same edge.
  always_comb begin
    hist_next = {history[PATTERN_W-2:0], bit_in};
    fill_next = (state == ST_FILL && fill != FULL) ? fill + 1'b1 : fill;
    accept    = bit_valid && !clear;
    hit       = accept && (hist_next == PATTERN) && (fill_next == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FILL;
      fill    <= '0;
      history <= '0;
      match   <= 1'b0;
    end else if (clear) begin
      state   <= ST_FILL;
      fill    <= '0;
      history <= '0;
      match   <= 1'b0;
    end else begin
      match <= hit;
      if (accept) begin
`ifdef SERIAL_DET_OVERLAP_EN
        history <= hist_next;
        fill    <= fill_next;
        if (fill_next == FULL) begin
          state <= ST_ARMED;
        end
`else
        // A detection consumes its bits, so the next match needs a full fresh window.
        if (hit) begin
          history <= '0;
          fill    <= '0;
          state   <= ST_FILL;
        end else begin
          history <= hist_next;
          fill    <= fill_next;
          if (fill_next == FULL) begin
            state <= ST_ARMED;
          end
        end
`endif
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (hit),
    .cnt  (match_count)
  );

endmodule
